// File: rtl/temp_pkg.sv
// temp_pkg: shared FSM states, active-low 7-segment codes, timing defaults and the double-dabble step.
package temp_pkg;
  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT, S_CAPTURE, S_CONVERT, S_UPDATE} state_t;
  localparam int DEF_PERIOD   = 100_000_000;
  localparam int DEF_TRIG_LOW = 50;
  localparam int DEF_SETTLE   = 1_500_000;
  localparam logic [7:0] DEF_ALARM_C = 8'd40;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_TAB [10] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};
  // One iteration on {hundreds, tens, ones, bin}: add 3 to nibbles >= 5, then shift left.
  function automatic logic [19:0] dd_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int i = 0; i < 3; i++)
      if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
    return {t[18:0], 1'b0};
  endfunction
endpackage

// File: rtl/temp_poll_display_seg7.sv
// seg7_decode: BCD digit to active-low {g,f,e,d,c,b,a}; blank input or non-decimal nibble shows nothing.
module seg7_decode
  import temp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb seg = (blank || bcd > 4'd9) ? SEG_BLANK : SEG_TAB[bcd];
endmodule

// File: rtl/temp_poll_display.sv
// temp_poll_display: periodic reader trigger, settle wait, capture, double-dabble and HEX/alarm output.
module temp_poll_display
  import temp_pkg::*;
#(
  parameter int         PERIOD   = DEF_PERIOD,
  parameter int         TRIG_LOW = DEF_TRIG_LOW,
  parameter int         SETTLE   = DEF_SETTLE,
  parameter logic [7:0] ALARM_C  = DEF_ALARM_C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  temp_data_in,
  output logic        trigger,
  output logic [11:0] temp_bcd,
  output logic [6:0]  hex2,
  output logic [6:0]  hex1,
  output logic [6:0]  hex0,
  output logic        overtemp,
  output logic        valid
);
  localparam int MAXC = PERIOD > SETTLE ? (PERIOD > TRIG_LOW ? PERIOD : TRIG_LOW)
                                        : (SETTLE > TRIG_LOW ? SETTLE : TRIG_LOW);
  localparam int CW = $clog2(MAXC + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [7:0] cap;
  logic [19:0] sr;
  logic last, trig_n, upd;
  logic [6:0] d2, d1, d0;
  logic b2, b1;
  always_ff @(posedge clk) state <= rst ? S_IDLE : state_n;
  always_comb begin
    last = (state == S_IDLE    && cnt == CW'(PERIOD - 1))
        || (state == S_TRIG    && cnt == CW'(TRIG_LOW - 1))
        || (state == S_WAIT    && cnt == CW'(SETTLE - 1))
        || (state == S_CONVERT && cnt == CW'(7))
        || state == S_CAPTURE || state == S_UPDATE;
    state_n = !last                ? state
            : state == S_IDLE      ? S_TRIG
            : state == S_TRIG      ? S_WAIT
            : state == S_WAIT      ? S_CAPTURE
            : state == S_CAPTURE   ? S_CONVERT
            : state == S_CONVERT   ? S_UPDATE
            :                        S_IDLE;
  end
  // Outputs are registered from next-state decode so trigger only moves on state edges.
  always_comb begin
    trig_n = state_n != S_TRIG;
    upd    = state == S_UPDATE;
    b2     = sr[19:16] == 4'd0;
    b1     = b2 && sr[15:12] == 4'd0;
  end
  seg7_decode u_d2 (.bcd(sr[19:16]), .blank(b2),   .seg(d2));
  seg7_decode u_d1 (.bcd(sr[15:12]), .blank(b1),   .seg(d1));
  seg7_decode u_d0 (.bcd(sr[11:8]),  .blank(1'b0), .seg(d0));
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      cap      <= '0;
      sr       <= '0;
      trigger  <= 1'b1;
      temp_bcd <= '0;
      hex2     <= SEG_BLANK;
      hex1     <= SEG_BLANK;
      hex0     <= SEG_BLANK;
      overtemp <= 1'b0;
      valid    <= 1'b0;
    end else begin
      cnt     <= last ? '0 : cnt + CW'(1);
      trigger <= trig_n;
      valid   <= upd;
      if (state == S_CAPTURE) begin
        cap <= temp_data_in;
        sr  <= {12'h000, temp_data_in};
      end
      if (state == S_CONVERT) sr <= dd_step(sr);
      if (upd) begin
        temp_bcd <= sr[19:8];
        hex2     <= d2;
        hex1     <= d1;
        hex0     <= d0;
        overtemp <= cap >= ALARM_C;
      end
    end
  end
endmodule

// File: doc/temp_poll_display.md
# temp_poll_display

Periodic poll-and-display stage wrapped around the single-wire temperature reader. Generates the reader's falling-edge `trigger` on a fixed schedule and waits for the sensor transaction to finish. Then captures the reader's 8-bit `temp_data_out`, converts it to BCD with a sequential double-dabble, and drives three active-low 7-segment digits plus an over-temperature flag. It sits between the reader and the board's HEX displays/LEDs.

## Interface
- `PERIOD`, 100_000_000, idle cycles between polls (2 s at 50 MHz; must exceed the worst-case reader transaction).
- `TRIG_LOW`, 50, cycles `trigger` is held low per poll (≥ 2 required by the reader's edge detector).
- `SETTLE`, 1_500_000, cycles waited after `trigger` rises before capture (30 ms; covers 20 ms start pulse plus data frame).
- `ALARM_C`, 8'd40, over-temperature threshold in °C.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `temp_data_in`  in  8  unsigned °C from the reader's `temp_data_out`.
- `trigger`  out  1  to reader `trigger`; idle high, low pulse starts a read.
- `temp_bcd`  out  12  {hundreds, tens, ones} BCD of last capture.
- `hex2`, `hex1`, `hex0`  out  7 each  active-low segments {g,f,e,d,c,b,a}, hundreds/tens/ones.
- `overtemp`  out  1  high while last capture ≥ `ALARM_C`.
- `valid`  out  1  one-cycle pulse when the outputs above update.

## Operation
- FSM states: IDLE → TRIG → WAIT → CAPTURE → CONVERT → UPDATE → IDLE.
- IDLE: counter counts 0..PERIOD-1; `trigger`=1; on PERIOD-1 clear counter, go TRIG.
- TRIG: `trigger`=0 for exactly TRIG_LOW cycles, then go WAIT.
- WAIT: `trigger`=1; count SETTLE cycles, then go CAPTURE.
- CAPTURE: latch `temp_data_in` into an internal 8-bit register (1 cycle). Later changes on `temp_data_in` are ignored until the next CAPTURE.
- CONVERT: double-dabble, 8 iterations, one per cycle, on a 20-bit shift register {12-bit BCD, 8-bit bin}. Each iteration: add 3 to any BCD nibble ≥ 5, then shift left 1. No other arithmetic.
- UPDATE (1 cycle): register `temp_bcd`, the three hex digits, and `overtemp` = (capture ≥ `ALARM_C`, unsigned 8-bit compare); pulse `valid`; go IDLE with counter 0.
- Leading-zero blanking: `hex2` blank (7'h7F) when hundreds=0; `hex1` blank when hundreds=0 and tens=0; `hex0` always shows a digit.
- Range 0..255 only; nibble values 0..9 only; any other nibble displays blank.
- The reader gives no completion handshake. SETTLE is the sole completion rule. A stale or failed reader transaction shows the reader's previous value; the block does not detect it.

## Timing
- Reset values: `trigger`=1, `temp_bcd`=12'h000, `hex2/1/0`=7'h7F (all blank), `overtemp`=0, `valid`=0, state IDLE, counter 0.
- First `trigger` fall: PERIOD cycles after the first clock with `rst` low.
- Poll cycle length: PERIOD + TRIG_LOW + SETTLE + 1 + 8 + 1 cycles, constant.
- Capture-to-`valid` latency: 10 cycles (CAPTURE edge to `valid` high is CONVERT 8 + UPDATE 1, registered).
- All outputs are registered; `trigger` changes only on FSM state edges, glitch-free.
- `rst` asserted in any state: next clock forces reset values, including `trigger`=1 mid-TRIG (truncated pulse) and conversion discarded. Displayed values are cleared to blank.
- `rst` held: outputs stay at reset values; no `trigger` activity.
- Counter width: $clog2 of max(PERIOD, SETTLE, TRIG_LOW)+1; 27 bits at defaults; never wraps (cleared on each state exit).

## Structure
- Package `temp_pkg`: FSM state enum (3-bit), 7-segment digit constants SEG_0..SEG_9 and SEG_BLANK (active-low), the default timing constants.
- Sub-module `seg7_decode`: combinational 4-bit BCD → 7-bit active-low with a blank input. Instantiated 3×, outputs registered in UPDATE.
- Double-dabble and FSM inline in `temp_poll_display`.

## Test plan
Test-bench overrides: PERIOD=100, TRIG_LOW=4, SETTLE=20.
- Reset release, `temp_data_in`=8'd25: `trigger` falls at cycle 100, low exactly 4 cycles. `valid` pulses at cycle 134. `temp_bcd`=12'h025, `hex2`=7'h7F, `hex1`=SEG_2, `hex0`=SEG_5, `overtemp`=0.
- `temp_data_in`=255 → `temp_bcd`=12'h255, all three digits lit. `temp_data_in`=0 → `hex2`,`hex1` blank, `hex0`=SEG_0.
- `temp_data_in`=39 then 40 on consecutive polls: `overtemp` 0 then 1. It changes only in the `valid` cycle.
- `temp_data_in` toggled every cycle during CONVERT: the result equals the value sampled at CAPTURE.
- `rst` asserted on the 2nd cycle of TRIG: `trigger`=1 on the next clock, outputs blank. The next `trigger` fall comes 100 cycles after release.
- Free-run 3 polls: `valid` pulses spaced exactly 134 cycles apart, one cycle wide each.
